// File: rtl/store_arbiter.sv
// store_arbiter: two-requester round-robin store arbiter with a single
// outstanding memory write, zero-byte-enable short-cut and timeout abort.
module store_arbiter #(
   parameter int TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0_valid,
   input  logic [31:0] req0_addr,
   input  logic [31:0] req0_wdata,
   input  logic [3:0]  req0_byteen,
   output logic        req0_ready,
   input  logic        req1_valid,
   input  logic [31:0] req1_addr,
   input  logic [31:0] req1_wdata,
   input  logic [3:0]  req1_byteen,
   output logic        req1_ready,
   output logic        m_valid,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   output logic [3:0]  m_byteen,
   input  logic        m_ack,
   output logic        done,
   output logic        done_id,
   output logic        err
);

   typedef enum logic {IDLE, BUSY} state_t;

   localparam logic [7:0] LastWait = 8'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic        lastGrant_q, lastGrant_d;
   logic [7:0]  waitCnt_q, waitCnt_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  byteen_q, byteen_d;
   logic        owner_q, owner_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic        doneId_q, doneId_d;
   logic        acceptGap_q, acceptGap_d;

   logic        anyValid;
   logic        grantId;
   logic        accept;
   logic        timeoutHit;
   logic [31:0] grantAddr;
   logic [31:0] grantWdata;
   logic [3:0]  grantByteen;

   // Pick the winner: a lone requester wins, a tie goes to whoever did not win last.
   // Accepts are held off while in reset, while busy and in the cycle right after an accept.
   always_comb begin
      anyValid    = req0_valid | req1_valid;
      grantId     = (req0_valid & req1_valid) ? ~lastGrant_q : req1_valid;
      accept      = reset && (state_q == IDLE) && !acceptGap_q && anyValid;
      timeoutHit  = (state_q == BUSY) && !m_ack && (waitCnt_q == LastWait);
      grantAddr   = grantId ? req1_addr   : req0_addr;
      grantWdata  = grantId ? req1_wdata  : req0_wdata;
      grantByteen = grantId ? req1_byteen : req0_byteen;
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: a store with live byte lanes goes to memory; BUSY ends on ack or timeout.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (accept && (grantByteen != 4'd0)) state_d = BUSY;
         BUSY: if (m_ack || timeoutHit) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath next values: capture on accept, count unacknowledged BUSY cycles, build pulses.
   always_comb begin
      lastGrant_d = lastGrant_q;
      waitCnt_d   = waitCnt_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      byteen_d    = byteen_q;
      owner_d     = owner_q;
      done_d      = 1'b0;
      err_d       = 1'b0;
      doneId_d    = doneId_q;
      acceptGap_d = accept;
      if (accept) begin
         addr_d      = grantAddr;
         wdata_d     = grantWdata;
         byteen_d    = grantByteen;
         owner_d     = grantId;
         lastGrant_d = grantId;
         waitCnt_d   = 8'd0;
         if (grantByteen == 4'd0) begin
            done_d   = 1'b1;
            doneId_d = grantId;
         end
      end
      if (state_q == BUSY) begin
         if (m_ack) begin
            done_d   = 1'b1;
            doneId_d = owner_q;
         end else if (timeoutHit) begin
            err_d    = 1'b1;
            doneId_d = owner_q;
         end else begin
            waitCnt_d = waitCnt_q + 8'd1;
         end
      end
   end

   // Datapath registers; reset clears everything and hands the first tie to requester 0.
   always_ff @(posedge clk) begin
      if (!reset) begin
         lastGrant_q <= 1'b1;
         waitCnt_q   <= 8'd0;
         addr_q      <= 32'd0;
         wdata_q     <= 32'd0;
         byteen_q    <= 4'd0;
         owner_q     <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         doneId_q    <= 1'b0;
         acceptGap_q <= 1'b0;
      end else begin
         lastGrant_q <= lastGrant_d;
         waitCnt_q   <= waitCnt_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         byteen_q    <= byteen_d;
         owner_q     <= owner_d;
         done_q      <= done_d;
         err_q       <= err_d;
         doneId_q    <= doneId_d;
         acceptGap_q <= acceptGap_d;
      end
   end

   // Outputs: memory port live only in BUSY outside reset, readies follow the grant.
   always_comb begin
      m_valid    = reset && (state_q == BUSY);
      m_addr     = addr_q;
      m_wdata    = wdata_q;
      m_byteen   = m_valid ? byteen_q : 4'd0;
      req0_ready = accept && !grantId;
      req1_ready = accept && grantId;
      done       = done_q;
      err        = err_q;
      done_id    = doneId_q;
   end

endmodule
